// File: rtl/branch_target_unit_if.sv
// Request/result bundle for the PC-relative branch target unit.
// The master drives requests and pipeline controls; the slave returns registered results.
interface branch_target_unit_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
);
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [WIDTH-1:0] pc_in;
    logic [IMM_W-1:0] imm_in;
    logic             out_valid;
    logic [WIDTH-1:0] target_out;
    logic             carry_out;
    logic             ovf_out;

    modport master (
        output in_valid, stall, flush, pc_in, imm_in,
        input  out_valid, target_out, carry_out, ovf_out
    );

    modport slave (
        input  in_valid, stall, flush, pc_in, imm_in,
        output out_valid, target_out, carry_out, ovf_out
    );
endinterface

// File: rtl/branch_target_unit.sv
// Pipelined PC + (sext(imm) << SHIFT) target generator with carry/overflow flags.
// One or two register stages; the two-stage version splits the add at WIDTH/2.
module branch_target_unit #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 16,
    parameter int SHIFT  = 2,
    parameter int STAGES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    branch_target_unit_if.slave  bus
);
    localparam int HALF = WIDTH / 2;

    logic signed [IMM_W-1:0] imm_s;
    logic signed [WIDTH-1:0] imm_sext;
    logic        [WIDTH-1:0] ext;

    logic             out_valid_q;
    logic [WIDTH-1:0] target_q;
    logic             carry_q;
    logic             ovf_q;

    assign imm_s    = bus.imm_in;
    assign imm_sext = WIDTH'(imm_s);
    assign ext      = imm_sext << SHIFT;

    assign bus.out_valid  = out_valid_q;
    assign bus.target_out = target_q;
    assign bus.carry_out  = carry_q;
    assign bus.ovf_out    = ovf_q;

    generate
        if (STAGES == 1) begin : g_one_stage
            logic [WIDTH:0] sum;
            logic           ovf;

            assign sum = {1'b0, bus.pc_in} + {1'b0, ext};
            assign ovf = (bus.pc_in[WIDTH-1] == ext[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.pc_in[WIDTH-1]);

            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    out_valid_q <= 1'b0;
                    target_q    <= '0;
                    carry_q     <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (bus.flush) begin
                    out_valid_q <= 1'b0;
                end else if (!bus.stall) begin
                    out_valid_q <= bus.in_valid;
                    if (bus.in_valid) begin
                        target_q <= sum[WIDTH-1:0];
                        carry_q  <= sum[WIDTH];
                        ovf_q    <= ovf;
                    end
                end
            end
        end else begin : g_two_stage
            logic            s1_valid;
            logic [HALF-1:0] s1_lo;
            logic            s1_carry;
            logic [HALF-1:0] s1_pc_hi;
            logic [HALF-1:0] s1_ext_hi;
            logic [HALF:0]   lo_sum;
            logic [HALF:0]   hi_sum;
            logic            hi_ovf;

            assign lo_sum = {1'b0, bus.pc_in[HALF-1:0]} + {1'b0, ext[HALF-1:0]};
            assign hi_sum = {1'b0, s1_pc_hi} + {1'b0, s1_ext_hi} + {{HALF{1'b0}}, s1_carry};
            // Signed overflow depends only on the top bits, all of which live in the upper half.
            assign hi_ovf = (s1_pc_hi[HALF-1] == s1_ext_hi[HALF-1]) &&
                            (hi_sum[HALF-1] != s1_pc_hi[HALF-1]);

            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    s1_valid    <= 1'b0;
                    s1_lo       <= '0;
                    s1_carry    <= 1'b0;
                    s1_pc_hi    <= '0;
                    s1_ext_hi   <= '0;
                    out_valid_q <= 1'b0;
                    target_q    <= '0;
                    carry_q     <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (bus.flush) begin
                    s1_valid    <= 1'b0;
                    out_valid_q <= 1'b0;
                end else if (!bus.stall) begin
                    s1_valid    <= bus.in_valid;
                    out_valid_q <= s1_valid;
                    if (bus.in_valid) begin
                        s1_lo     <= lo_sum[HALF-1:0];
                        s1_carry  <= lo_sum[HALF];
                        s1_pc_hi  <= bus.pc_in[WIDTH-1:HALF];
                        s1_ext_hi <= ext[WIDTH-1:HALF];
                    end
                    if (s1_valid) begin
                        target_q <= {hi_sum[HALF-1:0], s1_lo};
                        carry_q  <= hi_sum[HALF];
                        ovf_q    <= hi_ovf;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: four instances (STAGES 1/2 x SHIFT 0/2) share one stimulus
// stream; a queue scoreboard checks every edge, plus directed vectors and sequences.
module tb_branch_target_unit;
    localparam int W  = 32;
    localparam int IW = 16;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          in_valid, stall, flush;
    logic [W-1:0]  pc_in;
    logic [IW-1:0] imm_in;

    always #5 Clk = ~Clk;

    branch_target_unit_if #(.WIDTH(W), .IMM_W(IW)) bus0 ();
    branch_target_unit_if #(.WIDTH(W), .IMM_W(IW)) bus1 ();
    branch_target_unit_if #(.WIDTH(W), .IMM_W(IW)) bus2 ();
    branch_target_unit_if #(.WIDTH(W), .IMM_W(IW)) bus3 ();

    assign {bus0.in_valid, bus0.stall, bus0.flush, bus0.pc_in, bus0.imm_in} = {in_valid, stall, flush, pc_in, imm_in};
    assign {bus1.in_valid, bus1.stall, bus1.flush, bus1.pc_in, bus1.imm_in} = {in_valid, stall, flush, pc_in, imm_in};
    assign {bus2.in_valid, bus2.stall, bus2.flush, bus2.pc_in, bus2.imm_in} = {in_valid, stall, flush, pc_in, imm_in};
    assign {bus3.in_valid, bus3.stall, bus3.flush, bus3.pc_in, bus3.imm_in} = {in_valid, stall, flush, pc_in, imm_in};

    branch_target_unit #(.WIDTH(W), .IMM_W(IW), .SHIFT(2), .STAGES(2)) dut0 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus0.slave));
    branch_target_unit #(.WIDTH(W), .IMM_W(IW), .SHIFT(2), .STAGES(1)) dut1 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus1.slave));
    branch_target_unit #(.WIDTH(W), .IMM_W(IW), .SHIFT(0), .STAGES(2)) dut2 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus2.slave));
    branch_target_unit #(.WIDTH(W), .IMM_W(IW), .SHIFT(0), .STAGES(1)) dut3 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus3.slave));

    logic         ov [4];
    logic [W-1:0] tg [4];
    logic         cy [4];
    logic         of [4];

    assign ov[0] = bus0.out_valid; assign tg[0] = bus0.target_out; assign cy[0] = bus0.carry_out; assign of[0] = bus0.ovf_out;
    assign ov[1] = bus1.out_valid; assign tg[1] = bus1.target_out; assign cy[1] = bus1.carry_out; assign of[1] = bus1.ovf_out;
    assign ov[2] = bus2.out_valid; assign tg[2] = bus2.target_out; assign cy[2] = bus2.carry_out; assign of[2] = bus2.ovf_out;
    assign ov[3] = bus3.out_valid; assign tg[3] = bus3.target_out; assign cy[3] = bus3.carry_out; assign of[3] = bus3.ovf_out;

    typedef struct {
        logic [W-1:0] tgt;
        logic         c;
        logic         o;
        int           due;
    } exp_t;

    typedef struct {
        logic [W-1:0]  pc;
        logic [IW-1:0] imm;
        logic [W-1:0]  tgt;
        logic          c;
        logic          o;
    } vec_t;

    exp_t sb_q [4][$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   nadv     = 0;
    int   pulses0  = 0;

    logic         p_ov [4];
    logic [W-1:0] p_tg [4];
    logic         p_cy [4];
    logic         p_of [4];

    function automatic int sh_of(input int d);
        return (d < 2) ? 2 : 0;
    endfunction

    function automatic int st_of(input int d);
        return (d % 2 == 0) ? 2 : 1;
    endfunction

    function automatic exp_t model(input logic [W-1:0] pc, input logic [IW-1:0] imm, input int sh);
        logic [W-1:0] ext;
        logic [W:0]   s;
        exp_t         e;
        ext   = {{(W-IW){imm[IW-1]}}, imm};
        ext   = ext << sh;
        s     = {1'b0, pc} + {1'b0, ext};
        e.tgt = s[W-1:0];
        e.c   = s[W];
        e.o   = (pc[W-1] == ext[W-1]) && (s[W-1] != pc[W-1]);
        e.due = 0;
        return e;
    endfunction

    task automatic chk_w(input string nm, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input int d, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %b expected %b", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Scoreboard: sample the controls at the edge, check all instances just after it.
    always @(posedge Clk) begin
        logic          r, f, s, v;
        logic [W-1:0]  pc;
        logic [IW-1:0] im;
        exp_t          e;
        r = Reset_n; f = flush; s = stall; v = in_valid; pc = pc_in; im = imm_in;
        #1;
        if (r && !f && !s) nadv++;
        for (int d = 0; d < 4; d++) begin
            if (!r) begin
                sb_q[d].delete();
                chk_b("reset_valid", d, ov[d], 1'b0);
                chk_w("reset_target", d, tg[d], '0);
                chk_b("reset_carry", d, cy[d], 1'b0);
                chk_b("reset_ovf", d, of[d], 1'b0);
            end else if (f) begin
                sb_q[d].delete();
                chk_b("flush_valid", d, ov[d], 1'b0);
                chk_w("flush_target_hold", d, tg[d], p_tg[d]);
                chk_b("flush_carry_hold", d, cy[d], p_cy[d]);
                chk_b("flush_ovf_hold", d, of[d], p_of[d]);
            end else if (s) begin
                chk_b("stall_valid_hold", d, ov[d], p_ov[d]);
                chk_w("stall_target_hold", d, tg[d], p_tg[d]);
                chk_b("stall_carry_hold", d, cy[d], p_cy[d]);
                chk_b("stall_ovf_hold", d, of[d], p_of[d]);
            end else begin
                if (v) begin
                    e     = model(pc, im, sh_of(d));
                    e.due = nadv + st_of(d) - 1;
                    sb_q[d].push_back(e);
                end
                if (sb_q[d].size() > 0 && sb_q[d][0].due == nadv) begin
                    e = sb_q[d].pop_front();
                    chk_b("out_valid", d, ov[d], 1'b1);
                    chk_w("target", d, tg[d], e.tgt);
                    chk_b("carry", d, cy[d], e.c);
                    chk_b("ovf", d, of[d], e.o);
                end else begin
                    chk_b("idle_valid", d, ov[d], 1'b0);
                    chk_w("idle_target_hold", d, tg[d], p_tg[d]);
                end
                if (d == 0 && ov[0]) pulses0++;
            end
            p_ov[d] = ov[d]; p_tg[d] = tg[d]; p_cy[d] = cy[d]; p_of[d] = of[d];
        end
    end

    task automatic step(input logic v, input logic [W-1:0] pc, input logic [IW-1:0] im,
                        input logic s, input logic f, input logic rn);
        @(negedge Clk);
        in_valid = v; pc_in = pc; imm_in = im; stall = s; flush = f; Reset_n = rn;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    vec_t tbl [6];
    int   base;
    int   rnd;
    logic [W-1:0] corner [4];

    initial begin
        Reset_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; pc_in = '0; imm_in = '0;

        tbl[0] = '{pc: 32'h0000_0004, imm: 16'h0003, tgt: 32'h0000_0010, c: 1'b0, o: 1'b0};
        tbl[1] = '{pc: 32'h0000_0010, imm: 16'hFFFF, tgt: 32'h0000_000C, c: 1'b1, o: 1'b0};
        tbl[2] = '{pc: 32'h0000_FFFC, imm: 16'h0001, tgt: 32'h0001_0000, c: 1'b0, o: 1'b0};
        tbl[3] = '{pc: 32'h7FFF_FFFC, imm: 16'h0001, tgt: 32'h8000_0000, c: 1'b0, o: 1'b1};
        tbl[4] = '{pc: 32'h8000_0000, imm: 16'hFFFF, tgt: 32'h7FFF_FFFC, c: 1'b1, o: 1'b1};
        tbl[5] = '{pc: 32'h0040_0000, imm: 16'h8000, tgt: 32'h003E_0000, c: 1'b1, o: 1'b0};
        corner[0] = 32'h7FFF_FFFC; corner[1] = 32'h8000_0000;
        corner[2] = 32'hFFFF_FFFC; corner[3] = 32'h0000_FFFC;

        repeat (3) @(negedge Clk);
        idle(2);

        // Directed vectors: dut1 (one stage) after one edge, dut0 (two stages) after two.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i].pc, tbl[i].imm, 1'b0, 1'b0, 1'b1);
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            chk_b("tbl_s1_valid", 1, ov[1], 1'b1);
            chk_w("tbl_s1_target", 1, tg[1], tbl[i].tgt);
            chk_b("tbl_s1_carry", 1, cy[1], tbl[i].c);
            chk_b("tbl_s1_ovf", 1, of[1], tbl[i].o);
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            chk_b("tbl_s2_valid", 0, ov[0], 1'b1);
            chk_w("tbl_s2_target", 0, tg[0], tbl[i].tgt);
            chk_b("tbl_s2_carry", 0, cy[0], tbl[i].c);
            chk_b("tbl_s2_ovf", 0, of[0], tbl[i].o);
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            chk_b("tbl_s2_pulse_end", 0, ov[0], 1'b0);
            chk_w("tbl_s2_target_held", 0, tg[0], tbl[i].tgt);
        end

        // Stall: A, B, then C stalled for two edges and re-presented.
        idle(3);
        @(negedge Clk); base = pulses0;
        step(1'b1, 32'h0000_1000, 16'h0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_2000, 16'h0002, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_3000, 16'h0003, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h0000_3000, 16'h0003, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h0000_3000, 16'h0003, 1'b0, 1'b0, 1'b1);
        idle(3);
        @(negedge Clk);
        chk_i("stall_seq_pulses", pulses0 - base, 3);

        // Flush: A in flight and B presented on the flush edge are both lost.
        base = pulses0;
        step(1'b1, 32'h0000_4000, 16'h0004, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_5000, 16'h0005, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_6000, 16'h0006, 1'b0, 1'b0, 1'b1);
        idle(3);
        @(negedge Clk);
        chk_i("flush_seq_pulses", pulses0 - base, 1);

        // Reset with two items in flight: nothing may emerge afterwards.
        step(1'b1, 32'h0000_7000, 16'h0007, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0000_8000, 16'h0008, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        base = pulses0;
        idle(4);
        @(negedge Clk);
        chk_i("reset_seq_pulses", pulses0 - base, 0);

        // Randomised traffic across all four configurations.
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] pc;
            rnd = $urandom_range(0, 99);
            pc  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            step($urandom_range(0, 99) < 60, pc, 16'($urandom_range(0, 65535)),
                 rnd >= 6 && rnd < 21, rnd >= 1 && rnd < 6, rnd != 0);
        end
        idle(4);
        @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_target_unit.md
# branch_target_unit

Parametrised, pipelined PC-relative target generator for the branch/jump path of the datapath. Sign-extends and scales an immediate, adds it to a PC value, and delivers the target with carry and signed-overflow flags after one or two register stages. Valid, stall and flush controls let it sit inside the pipeline with hazard and squash control. It replaces a purely combinational PC-plus-offset adder.

## Interface
Parameters:
- WIDTH, 32, PC/target width; must be even and ≥ IMM_W
- IMM_W, 16, immediate field width
- SHIFT, 2, left shift applied to the extended immediate; 0 ≤ SHIFT < WIDTH
- STAGES, 2, pipeline depth; legal values 1 or 2

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  pc_in/imm_in carry a request this cycle
- stall  in  1  freeze all stages
- flush  in  1  squash all in-flight and incoming requests
- pc_in  in  WIDTH  base PC
- imm_in  in  IMM_W  signed immediate (two's complement)
- out_valid  out  1  target_out/flags hold a new result this cycle
- target_out  out  WIDTH  pc_in + (sext(imm_in) << SHIFT), modulo 2^WIDTH
- carry_out  out  1  unsigned carry out of bit WIDTH-1
- ovf_out  out  1  signed overflow of the WIDTH-bit add

## Operation
- Extension: ext = imm_in sign-extended to WIDTH, then shifted left by SHIFT; bits shifted past WIDTH-1 are discarded, zeros shift in.
- Sum: {carry, sum} = pc_in + ext, computed in WIDTH+1 bits. ovf = (pc_in[MSB] == ext[MSB]) && (sum[MSB] != pc_in[MSB]).
- STAGES=1: one register stage holds valid, sum, carry, ovf.
- STAGES=2: stage 1 adds the low WIDTH/2 bits and registers the low sum, the low-half carry, the upper halves of both operands and valid. Stage 2 adds the upper halves plus the registered carry and produces target, carry_out and ovf_out. Result must equal the STAGES=1 result bit-for-bit.
- Each stage has a valid bit. Data registers of a stage load only when that stage accepts a valid item. Otherwise they hold, so outputs keep the last valid result while out_valid=0.
- Priority per edge: Reset_n=0 > flush > stall > normal advance.
  - flush=1: all valid bits cleared; an in_valid on the same cycle is dropped; data registers hold.
  - stall=1 (flush=0): every register holds, including out_valid; in_valid is ignored and the requester must re-present the input.
  - Normal: every stage advances; throughput is one request per cycle.
- No internal state beyond the stage registers; there is no FSM and no back-pressure output.

## Timing
- Reset (Reset_n=0 at an edge): out_valid=0, target_out=0, carry_out=0, ovf_out=0, all internal valid and data registers 0.
- Reset asserted mid-stream discards all in-flight items at that edge. The first input accepted after release appears after the normal latency.
- Latency: STAGES cycles from the in_valid edge to out_valid=1, counting only non-stalled edges. Each stalled edge adds one cycle.
- out_valid is a one-cycle pulse per accepted item unless held by stall. Under stall, out_valid and the data outputs hold unchanged.
- Back-to-back requests emerge in order on consecutive cycles.
- Stall and flush on the same edge: flush wins; result is all valid bits 0.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Defaults WIDTH=32, IMM_W=16, SHIFT=2, STAGES=2 unless noted.
- Basic: pc_in=0x00000004, imm_in=0x0003, in_valid for 1 cycle -> two edges later out_valid=1, target_out=0x00000010, carry_out=0, ovf_out=0. The next cycle has out_valid=0 and target_out held.
- Negative offset and half-boundary carry: imm_in=0xFFFF, pc_in=0x00000010 -> target 0x0000000C, carry_out=1, ovf_out=0. Then pc_in=0x0000FFFC, imm_in=0x0001 -> 0x00010000, carry_out=0.
- Overflow: pc_in=0x7FFFFFFC, imm_in=0x0001 -> target 0x80000000, ovf_out=1, carry_out=0. Then pc_in=0x80000000, imm_in=0xFFFF -> 0x7FFFFFFC, ovf_out=1, carry_out=1.
- Stall/flush: inputs A, B, C on consecutive cycles with stall high on cycles 2–3 (C re-presented after the stall) -> outputs emerge in order A, B, C with 2 extra cycles of latency and held outputs during the stall. Repeat with flush on cycle 2 -> only items presented after the flush produce out_valid.
- Reset and depth: with STAGES=1, pc_in=0x00400000, imm_in=0x8000 -> one edge later target 0x003E0000, ovf_out=0. Assert Reset_n=0 with 2 items in flight under STAGES=2 -> all outputs 0 on the next edge, with no stale out_valid after release.
- Randomised: 10k random pc_in/imm_in/in_valid/stall/flush sequences compared against a reference model for both STAGES values, with SHIFT ∈ {0, 2}.
